// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding and width helpers for the serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A counter for a single step still needs one bit to exist.
    function automatic int cnt_width(input int steps);
        return (clog2(steps) < 1) ? 1 : clog2(steps);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result valid-ready handshake bundle
interface serial_adder_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

endinterface

// File: rtl/serial_adder_cell.sv
// full_adder_cell: one-bit combinational full adder
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle a+b+cin, SLICE bits per clock, valid/ready on both sides
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_if.slave   bus
);

    localparam int STEPS = WIDTH / SLICE;
    localparam int CNT_W = cnt_width(STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    if (SLICE < 1 || WIDTH % SLICE != 0) begin : g_bad_slice
        $error("serial_adder: SLICE must divide WIDTH");
    end

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [WIDTH-1:0]       a_q, b_q, sum_q;
    logic                   carry_q, cout_q, ovf_q;
    logic [SLICE:0]         c;
    logic [SLICE-1:0]       s;
    logic [WIDTH+SLICE-1:0] sum_cat;
    logic [WIDTH-1:0]       a_d, b_d, sum_d;

    // The carry register feeds the bottom of the cell chain; its top feeds back next cycle.
    assign c[0] = carry_q;

    for (genvar i = 0; i < SLICE; i++) begin : g_cell
        full_adder_cell u_cell (
            .a_i    (a_q[i]),
            .b_i    (b_q[i]),
            .cin_i  (c[i]),
            .s_o    (s[i]),
            .cout_o (c[i+1])
        );
    end

    // New slice enters the sum from the MSB side so the last step leaves it aligned.
    assign sum_cat = {s, sum_q};
    assign sum_d   = sum_cat[WIDTH+SLICE-1:SLICE];
    assign a_d     = a_q >> SLICE;
    assign b_d     = b_q >> SLICE;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    // Control FSM with step counter, operand/sum shifters and carry/overflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_q     <= bus.a;
                    b_q     <= bus.b;
                    carry_q <= bus.cin;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    sum_q   <= sum_d;
                    carry_q <= c[SLICE];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        cout_q  <= c[SLICE];
                        ovf_q   <= c[SLICE] ^ c[SLICE-1];
                        state_q <= DONE;
                    end
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the serial adder at 8/1, 4/2 and 4/4
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(4)) if42 ();
    serial_adder_if #(.WIDTH(4)) if44 ();

    serial_adder #(.WIDTH(8), .SLICE(1)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_adder #(.WIDTH(4), .SLICE(2)) dut42 (.clk(clk), .rst(rst), .bus(if42.slave));
    serial_adder #(.WIDTH(4), .SLICE(4)) dut44 (.clk(clk), .rst(rst), .bus(if44.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xact8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input logic [7:0] es, input logic ec, input logic eo);
        int n;
        check({tag, "_in_ready"}, 32'(if8.in_ready), 1);
        if8.a = av;
        if8.b = bv;
        if8.cin = cv;
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        check({tag, "_busy"}, 32'(if8.busy), 1);
        n = 0;
        while (!if8.out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_sum"}, 32'(if8.sum), 32'(es));
        check({tag, "_cout"}, 32'(if8.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(if8.ovf), 32'(eo));
        tick();
        check({tag, "_valid_drop"}, 32'(if8.out_valid), 0);
        check({tag, "_ready_back"}, 32'(if8.in_ready), 1);
    endtask

    initial begin
        int n, v;
        logic [3:0] av, bv, es;
        logic cv, got42, got44;
        logic [4:0] full;
        logic [5:0] expv;
        rst = 1'b1;
        {if8.in_valid, if8.a, if8.b, if8.cin, if8.out_ready} = '0;
        {if42.in_valid, if42.a, if42.b, if42.cin} = '0;
        {if44.in_valid, if44.a, if44.b, if44.cin} = '0;
        if42.out_ready = 1'b1;
        if44.out_ready = 1'b1;
        tick();
        check("rst_in_ready_low", 32'(if8.in_ready), 0);
        check("rst_out_valid", 32'(if8.out_valid), 0);
        check("rst_busy", 32'(if8.busy), 0);
        tick();
        rst = 1'b0;
        if8.out_ready = 1'b1;
        #1;
        check("rst_in_ready_high", 32'(if8.in_ready), 1);
        check("rst_sum", 32'(if8.sum), 0);
        check("rst_cout", 32'(if8.cout), 0);
        check("rst_ovf", 32'(if8.ovf), 0);

        xact8("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        xact8("ff_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        xact8("ff_ff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        xact8("7f_01",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        xact8("80_80",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Backpressure: result 05+03 held while the consumer stalls.
        if8.out_ready = 1'b0;
        if8.a = 8'h05;
        if8.b = 8'h03;
        if8.cin = 1'b0;
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        n = 0;
        while (!if8.out_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_latency", n, 8);
        for (int k = 0; k < 5; k++) begin
            if8.a = 8'h11;
            if8.b = 8'h11;
            if8.in_valid = 1'b1;
            tick();
            check("bp_valid_held", 32'(if8.out_valid), 1);
            check("bp_sum_held", 32'(if8.sum), 32'h08);
            check("bp_in_ready", 32'(if8.in_ready), 0);
            check("bp_busy", 32'(if8.busy), 1);
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(if8.out_valid), 0);
        check("bp_release_ready", 32'(if8.in_ready), 1);
        check("bp_idle_sum_kept", 32'(if8.sum), 32'h08);

        // Reset in the middle of RUN abandons the operation.
        if8.a = 8'hAA;
        if8.b = 8'h55;
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy", 32'(if8.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(if8.out_valid), 0);
        check("mid_rst_busy", 32'(if8.busy), 0);
        check("mid_rst_ready", 32'(if8.in_ready), 1);
        check("mid_rst_sum", 32'(if8.sum), 0);
        xact8("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep on the two-slice and one-step variants in lockstep.
        for (v = 0; v < 512; v++) begin
            av = v[3:0];
            bv = v[7:4];
            cv = v[8];
            full = 5'(av) + 5'(bv) + 5'(cv);
            es = full[3:0];
            expv = {full[4], (av[3] == bv[3]) && (es[3] != av[3]), es};
            {if42.a, if42.b, if42.cin} = {av, bv, cv};
            {if44.a, if44.b, if44.cin} = {av, bv, cv};
            if42.in_valid = 1'b1;
            if44.in_valid = 1'b1;
            tick();
            if42.in_valid = 1'b0;
            if44.in_valid = 1'b0;
            n = 0;
            got42 = 1'b0;
            got44 = 1'b0;
            while ((!got42 || !got44) && n < 10) begin
                tick();
                n++;
                if (!got42 && if42.out_valid) begin
                    got42 = 1'b1;
                    check("s2_latency", n, 2);
                    check("s2_result", 32'({if42.cout, if42.ovf, if42.sum}), 32'(expv));
                end
                if (!got44 && if44.out_valid) begin
                    got44 = 1'b1;
                    check("s4_latency", n, 1);
                    check("s4_result", 32'({if44.cout, if44.ovf, if44.sum}), 32'(expv));
                end
            end
            check("sweep_done", 32'({got42, got44}), 32'b11);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
